// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryption core with ECB/CTR modes and on-the-fly key expansion.
// ROUNDS_PER_CYCLE rounds (1, 2, 5 or 10) are evaluated per clock between valid/ready handshakes.
module aes_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int CTR_INC_BITS     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    input  logic         mode,
    input  logic         ctr_load,
    input  logic [127:0] iv_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic [127:0] ctr_value
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
        $fatal(1, "aes_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [127:0] CTR_MASK = (128'd1 << CTR_INC_BITS) - 128'd1;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box = affine map of the GF(2^8) inverse, computed as x^254 (0 maps to 0).
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
        r = gf_mul(r, r);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t       state_q, state_d;
    logic [3:0]   round_cnt_q, round_cnt_d;
    logic [127:0] st_q, st_d, rk_q, rk_d, data_q, data_d;
    logic [127:0] dout_q, dout_d, ctr_q, ctr_d;
    logic         mode_q, mode_d;
    logic [127:0] ctr_eff, ctr_inc, st_last, rk_last;

    // Round chain: each stage derives its round key from the previous one, then applies the round.
    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
        logic [127:0] st_i, rk_i, st_o, rk_o;
        logic [3:0]   rnd;
        if (g == 0) begin : g_first
            assign st_i = st_q;
            assign rk_i = rk_q;
        end else begin : g_next
            assign st_i = g_rnd[g-1].st_o;
            assign rk_i = g_rnd[g-1].rk_o;
        end
        assign rnd  = round_cnt_q + 4'(g + 1);
        assign rk_o = key_expand(rk_i, rcon(rnd));
        assign st_o = (rnd == 4'd10) ? (shift_rows(sub_bytes(st_i)) ^ rk_o)
                                     : (mix_columns(shift_rows(sub_bytes(st_i))) ^ rk_o);
    end

    assign st_last = g_rnd[ROUNDS_PER_CYCLE-1].st_o;
    assign rk_last = g_rnd[ROUNDS_PER_CYCLE-1].rk_o;

    // A same-cycle ctr_load takes effect for the block being accepted.
    assign ctr_eff = ctr_load ? iv_in : ctr_q;
    assign ctr_inc = (ctr_eff & ~CTR_MASK) | ((ctr_eff + 128'd1) & CTR_MASK);

    always_comb begin
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        st_d        = st_q;
        rk_d        = rk_q;
        data_d      = data_q;
        mode_d      = mode_q;
        dout_d      = dout_q;
        ctr_d       = ctr_load ? iv_in : ctr_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rk_d        = key_in;
                    mode_d      = mode;
                    data_d      = data_in;
                    st_d        = (mode ? ctr_eff : data_in) ^ key_in;
                    round_cnt_d = 4'd0;
                    state_d     = RUN;
                    if (mode) ctr_d = ctr_inc;
                end
            end
            RUN: begin
                st_d        = st_last;
                rk_d        = rk_last;
                round_cnt_d = round_cnt_q + 4'(ROUNDS_PER_CYCLE);
                if (round_cnt_d == 4'd10) begin
                    dout_d  = st_last ^ (mode_q ? data_q : 128'd0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            round_cnt_q <= 4'd0;
            st_q        <= 128'd0;
            rk_q        <= 128'd0;
            data_q      <= 128'd0;
            mode_q      <= 1'b0;
            dout_q      <= 128'd0;
            ctr_q       <= 128'd0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            dout_q      <= dout_d;
            ctr_q       <= ctr_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign data_out  = dout_q;
    assign ctr_value = ctr_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS-197 and SP800-38A vectors across 1/2/5/10 rounds per clock.
module tb_aes_iter_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, mode, ctr_load, out_ready;
    logic [127:0] data_in, key_in, iv_in;

    logic         rdy1, ov1, rdy2, ov2, rdy5, ov5, rdy10, ov10;
    logic [127:0] dout1, ctr1, dout2, ctr2, dout5, ctr5, dout10, ctr10;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] IV_F5 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

    always #5 clk = ~clk;

    aes_iter_core #(.ROUNDS_PER_CYCLE(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .data_in(data_in),
        .key_in(key_in), .mode(mode), .ctr_load(ctr_load), .iv_in(iv_in), .out_valid(ov1),
        .out_ready(out_ready), .data_out(dout1), .ctr_value(ctr1));
    aes_iter_core #(.ROUNDS_PER_CYCLE(2)) u_r2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .data_in(data_in),
        .key_in(key_in), .mode(mode), .ctr_load(ctr_load), .iv_in(iv_in), .out_valid(ov2),
        .out_ready(out_ready), .data_out(dout2), .ctr_value(ctr2));
    aes_iter_core #(.ROUNDS_PER_CYCLE(5)) u_r5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy5), .data_in(data_in),
        .key_in(key_in), .mode(mode), .ctr_load(ctr_load), .iv_in(iv_in), .out_valid(ov5),
        .out_ready(out_ready), .data_out(dout5), .ctr_value(ctr5));
    aes_iter_core #(.ROUNDS_PER_CYCLE(10)) u_r10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy10), .data_in(data_in),
        .key_in(key_in), .mode(mode), .ctr_load(ctr_load), .iv_in(iv_in), .out_valid(ov10),
        .out_ready(out_ready), .data_out(dout10), .ctr_value(ctr10));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one block at the current negedge; returns after the accepting edge with in_valid low.
    task automatic offer(input logic [127:0] k, input logic [127:0] d, input logic m);
        key_in   = k;
        data_in  = d;
        mode     = m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = '0;
        key_in   = '0;
    endtask

    // Count negedges until the R=1 core raises out_valid, bounded.
    task automatic wait_r1(output int n);
        n = 0;
        while (!ov1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; ctr_load = 1'b0; out_ready = 1'b1;
        data_in = '0; key_in = '0; iv_in = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 128'(rdy1), 128'd1);
        check("rst_out_valid", 128'(ov1), 128'd0);
        check("rst_data_out", dout1, 128'd0);
        check("rst_ctr", ctr1, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ECB, one round per clock, cycle-by-cycle handshake view
        offer(K_C1, P_C1, 1'b0);
        check("s1_ready_e0", 128'(rdy1), 128'd0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("s1_ready_e%0d", i), 128'(rdy1), 128'd0);
            check($sformatf("s1_valid_e%0d", i), 128'(ov1), (i == 10) ? 128'd1 : 128'd0);
        end
        check("s1_data", dout1, C_C1);
        @(negedge clk);
        check("s1_valid_drop", 128'(ov1), 128'd0);
        check("s1_ready_back", 128'(rdy1), 128'd1);

        // ECB at 10, 5 and 2 rounds per clock
        offer(K_B, P_B, 1'b0);
        check("s2_r10_e0", 128'(ov10), 128'd0);
        @(negedge clk);
        check("s2_r10_valid", 128'(ov10), 128'd1);
        check("s2_r10_data", dout10, C_B);
        check("s2_r5_e1", 128'(ov5), 128'd0);
        @(negedge clk);
        check("s2_r5_valid", 128'(ov5), 128'd1);
        check("s2_r5_data", dout5, C_B);
        check("s2_r2_e2", 128'(ov2), 128'd0);
        repeat (3) @(negedge clk);
        check("s2_r2_valid", 128'(ov2), 128'd1);
        check("s2_r2_data", dout2, C_B);
        wait_r1(lat);
        check("s2_r1_data", dout1, C_B);
        check("s2_ecb_ctr_untouched", ctr1, 128'd0);
        @(negedge clk);

        // CTR with load coinciding with the first accept
        iv_in = IV_F5;
        ctr_load = 1'b1;
        key_in = K_B; data_in = 128'h6bc1bee22e409f96e93d7e117393172a; mode = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        ctr_load = 1'b0; in_valid = 1'b0;
        check("s3_ctr_after_load", ctr1, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);
        wait_r1(lat);
        check("s3_lat1", 128'(lat), 128'd10);
        check("s3_blk1", dout1, 128'h874d6191b620e3261bef6864990db6ce);
        @(negedge clk);
        offer(K_B, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1);
        wait_r1(lat);
        check("s3_blk2", dout1, 128'h9806f66b7970fdff8617187bb9fffdff);
        check("s3_ctr_end", ctr1, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01);
        @(negedge clk);

        // Counter wrap stays inside the low 32 bits
        iv_in = 128'h000102030405060708090a0bffffffff;
        ctr_load = 1'b1;
        @(negedge clk);
        ctr_load = 1'b0;
        check("s4_ctr_loaded", ctr1, 128'h000102030405060708090a0bffffffff);
        offer(K_B, P_B, 1'b1);
        check("s4_ctr_wrap", ctr1, 128'h000102030405060708090a0b00000000);
        wait_r1(lat);
        check("s4_lat", 128'(lat), 128'd10);
        @(negedge clk);

        // Backpressure: hold DONE while a new block is offered
        out_ready = 1'b0;
        offer(K_C1, P_C1, 1'b0);
        wait_r1(lat);
        check("s5_data", dout1, C_C1);
        in_valid = 1'b1; data_in = 128'hdeadbeef; key_in = K_B;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("s5_hold_valid%0d", i), 128'(ov1), 128'd1);
            check($sformatf("s5_hold_data%0d", i), dout1, C_C1);
            check($sformatf("s5_hold_ready%0d", i), 128'(rdy1), 128'd0);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("s5_release_valid", 128'(ov1), 128'd0);
        check("s5_release_ready", 128'(rdy1), 128'd1);

        // Asynchronous reset in the middle of RUN
        offer(K_C1, P_C1, 1'b0);
        repeat (4) @(negedge clk);
        check("s6_pre_ready", 128'(rdy1), 128'd0);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_ready", 128'(rdy1), 128'd1);
        check("s6_rst_valid", 128'(ov1), 128'd0);
        check("s6_rst_data", dout1, 128'd0);
        check("s6_rst_ctr", ctr1, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        offer(K_C1, P_C1, 1'b0);
        wait_r1(lat);
        check("s6_lat", 128'(lat), 128'd10);
        check("s6_data", dout1, C_C1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
Iterative AES-128 encryption engine, the parametrised successor to the fully-unrolled AES top.
- Round-key expansion is done on the fly, so there are no ten parallel round-key buses.
- The number of AES rounds evaluated per clock is set by a parameter.
- Adds ECB and CTR modes with an internal 128-bit counter.
- Uses valid/ready handshakes on input and output.
- Sits between the host data path and the result FIFO; reuses the team's combinational round, final_round and S-box blocks.

Parameters:
ROUNDS_PER_CYCLE, 1, AES rounds per clock; legal values 1, 2, 5, 10; any other value is a fatal elaboration error.
CTR_INC_BITS, 32, low counter bits incremented per block; upper bits never change.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  block offered
in_ready  out  1  core can accept a block
data_in  in  128  plaintext (ECB) or data to XOR (CTR)
key_in  in  128  cipher key, sampled with each accepted block
mode  in  1  0 = ECB, 1 = CTR; sampled on accept
ctr_load  in  1  load counter from iv_in
iv_in  in  128  initial counter block
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
data_out  out  128  ciphertext
ctr_value  out  128  current counter register

Behaviour:
- Reset (asynchronous, active-low) clears every register, regardless of state:
  - state = IDLE; in_ready = 1; out_valid = 0; data_out = 0; ctr_value = 0.
  - An in-flight block is discarded.
- Three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - Accept when in_valid && in_ready.
  - On accept, register the key and mode. Register data_in for CTR use.
  - Load state = (mode ? ctr : data_in) ^ key_in. Set round_cnt = 0. Go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, apply ROUNDS_PER_CYCLE rounds, expanding the next ROUNDS_PER_CYCLE round keys combinationally from the registered round key.
  - round_cnt += ROUNDS_PER_CYCLE.
  - Round 10 uses final_round (no MixColumns).
  - When round_cnt reaches 10, register data_out and go to DONE.
    - ECB: data_out = cipher result.
    - CTR: data_out = cipher result ^ registered data.
- DONE:
  - out_valid = 1; data_out is stable until the handshake.
  - On out_ready, out_valid drops next cycle and state returns to IDLE.
  - The core does not accept a block in the same cycle it hands one off.
- Latency: accept at edge N gives out_valid high after edge N + 10/ROUNDS_PER_CYCLE. If out_ready is held high, throughput is one block per 10/ROUNDS_PER_CYCLE + 2 cycles.
- Counter:
  - ctr_load in any state loads ctr = iv_in at the next edge.
  - On accepting a CTR-mode block, ctr increments its low CTR_INC_BITS modulo 2^CTR_INC_BITS. The upper bits are unchanged.
  - ECB blocks never touch ctr.
- Simultaneous ctr_load and CTR accept: the block uses iv_in as its counter, and the register ends as iv_in + 1.
- ctr_load during RUN or DONE does not affect the block in flight.
- data_in, key_in and mode are ignored outside the accept cycle.
- Backpressure: out_ready low holds DONE indefinitely, with no data loss and in_ready low.

Test Plan:
1. ECB, ROUNDS_PER_CYCLE=1, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, accepted at edge 0 -> out_valid rises after edge 10 with data_out 69c4e0d86a7b0430d8cdb78070b4c55a; in_ready low edges 1-10.
2. ECB, ROUNDS_PER_CYCLE=2, 5 and 10, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32 after 5, 2 and 1 cycles respectively.
3. CTR, key 2b7e..4f3c, ctr_load with iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff:
   - block 6bc1bee22e409f96e93d7e117393172a -> 874d6191b620e3261bef6864990db6ce.
   - next block ae2d8a571e03ac9c9eb76fac45af8e51 -> 9806f66b7970fdff8617187bb9fffdff.
   - ctr_value ends at ...f8f9fafbfcfdff01.
4. Counter wrap: iv 000102030405060708090a0bffffffff, one CTR block -> ctr_value 000102030405060708090a0b00000000.
5. Backpressure: hold out_ready low for 20 cycles in DONE -> out_valid and data_out stable, in_ready 0; assert out_ready -> out_valid low next cycle, in_ready 1.
6. Reset mid-RUN (rst_n low at round 4, asynchronous) -> outputs cleared immediately, ctr_value 0; the block issued after release encrypts correctly per scenario 1.
